// File: rtl/mem_load_stage_pkg.sv
// Shared encodings for the memory/load pipeline stage: load sizes, FSM states,
// and the width of the forwarding bundle {dest, data, busy}.
package mem_load_stage_pkg;

    localparam logic [1:0] LD_BYTE  = 2'd0;
    localparam logic [1:0] LD_HALF  = 2'd1;
    localparam logic [1:0] LD_WORD  = 2'd2;
    localparam logic [1:0] LD_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } stage_e;

    function automatic int fwd_bus_w(input int data_w);
        return 5 + data_w + 1;
    endfunction

endpackage

// File: rtl/mem_load_stage_if.sv
// EX/SRAM/WB-facing bundle of the memory stage; master is the surrounding
// pipeline, slave is the stage itself.
interface mem_load_stage_if #(
    parameter int DATA_W = 32,
    parameter int SB_W   = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_result;
    logic [4:0]        in_dest;
    logic              in_gr_we;
    logic              in_is_load;
    logic [1:0]        in_ld_size;
    logic              in_ld_signed;
    logic              in_ex;
    logic [SB_W-1:0]   in_sb;
    logic              req_fire;
    logic              data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [4:0]        out_dest;
    logic [DATA_W-1:0] out_result;
    logic              out_gr_we;
    logic              out_ex;
    logic [SB_W-1:0]   out_sb;
    logic              mem_ex;
    logic [4:0]        fwd_dest;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_busy;

    modport master (
        output in_valid, in_pc, in_result, in_dest, in_gr_we, in_is_load,
               in_ld_size, in_ld_signed, in_ex, in_sb, req_fire, data_ok,
               data_rdata, out_ready,
        input  in_ready, out_valid, out_pc, out_dest, out_result, out_gr_we,
               out_ex, out_sb, mem_ex, fwd_dest, fwd_data, fwd_busy
    );

    modport slave (
        input  in_valid, in_pc, in_result, in_dest, in_gr_we, in_is_load,
               in_ld_size, in_ld_signed, in_ex, in_sb, req_fire, data_ok,
               data_rdata, out_ready,
        output in_ready, out_valid, out_pc, out_dest, out_result, out_gr_we,
               out_ex, out_sb, mem_ex, fwd_dest, fwd_data, fwd_busy
    );

endinterface

// File: rtl/mem_load_stage_load_align_ext.sv
// Combinational lane select and sign/zero extension of load data; zero latency.
module load_align_ext
    import mem_load_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             data,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  logic [1:0]                    size,
    input  logic                          sign,
    output logic [DATA_W-1:0]             result
);
    localparam int OFF_W = $clog2(DATA_W/8);

    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;
    logic              msb;

    always_comb begin
        lane_off = offset;
        mask     = '1;
        case (size)
            LD_BYTE:  mask = DATA_W'(32'h0000_00FF);
            LD_HALF: begin
                lane_off[0] = 1'b0;
                mask        = DATA_W'(32'h0000_FFFF);
            end
            LD_WORD: begin
                lane_off[1:0] = 2'b00;
                mask          = DATA_W'(32'hFFFF_FFFF);
            end
            LD_DWORD: lane_off = '0;
            default: ;
        endcase
        shifted = data >> {lane_off, 3'b000};
        // Top bit of the field is the single bit set in mask ^ (mask >> 1).
        msb     = |(shifted & (mask ^ (mask >> 1)));
        result  = (shifted & mask) | ((sign && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_load_stage.sv
// EX->WB memory stage: tracks split-handshake loads, bypasses live data_ok data,
// drains stale responses after flush. in_ready = idle or output handshake.
module mem_load_stage
    import mem_load_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2,
    parameter int SB_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    mem_load_stage_if.slave   io
);
    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int FWD_W = fwd_bus_w(DATA_W);

    stage_e            state, state_n;
    logic [CNT_W-1:0]  out_count, discard_cnt, count_n;
    logic [31:0]       pc_q;
    logic [DATA_W-1:0] result_q, rdata_q;
    logic [4:0]        dest_q;
    logic              gr_we_q, is_load_q, ex_q, signed_q;
    logic [1:0]        size_q;
    logic [SB_W-1:0]   sb_q;

    logic              occupied, rsp_live, consume, out_valid, leave, in_ready, accept;
    logic [DATA_W-1:0] ld_src, ld_val, result;
    logic [FWD_W-1:0]  fwd_bus;

    assign occupied  = state != ST_IDLE;
    assign rsp_live  = io.data_ok && discard_cnt == '0;
    assign consume   = rsp_live && state == ST_WAIT;
    assign out_valid = state == ST_DONE || consume;
    assign leave     = out_valid && io.out_ready;
    assign in_ready  = !flush && (state == ST_IDLE || leave);
    assign accept    = io.in_valid && in_ready;
    assign count_n   = out_count + CNT_W'(io.req_fire) - CNT_W'(io.data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush)
            state_n = ST_IDLE;
        else if (accept)
            state_n = (io.in_is_load && !io.in_ex) ? ST_WAIT : ST_DONE;
        else if (leave)
            state_n = ST_IDLE;
        else if (consume)
            state_n = ST_DONE;
    end

    // Responses still owed to flushed instructions are counted and swallowed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_count   <= '0;
            discard_cnt <= '0;
        end else begin
            out_count <= count_n;
            if (flush)
                discard_cnt <= count_n;
            else if (io.data_ok && discard_cnt != '0)
                discard_cnt <= discard_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q      <= io.in_pc;
            result_q  <= io.in_result;
            dest_q    <= io.in_dest;
            gr_we_q   <= io.in_gr_we;
            is_load_q <= io.in_is_load && !io.in_ex;
            size_q    <= io.in_ld_size;
            signed_q  <= io.in_ld_signed;
            ex_q      <= io.in_ex;
            sb_q      <= io.in_sb;
        end
        if (consume)
            rdata_q <= io.data_rdata;
    end

    assign ld_src = (state == ST_WAIT) ? io.data_rdata : rdata_q;

    load_align_ext #(.DATA_W(DATA_W)) u_align (
        .data   (ld_src),
        .offset (result_q[OFF_W-1:0]),
        .size   (size_q),
        .sign   (signed_q),
        .result (ld_val)
    );

    assign result = !occupied ? '0 : (is_load_q ? ld_val : result_q);

    assign io.in_ready   = in_ready;
    assign io.out_valid  = out_valid;
    assign io.out_pc     = occupied ? pc_q : '0;
    assign io.out_dest   = occupied ? dest_q : '0;
    assign io.out_result = result;
    assign io.out_gr_we  = occupied && gr_we_q;
    assign io.out_ex     = occupied && ex_q;
    assign io.out_sb     = occupied ? sb_q : '0;
    assign io.mem_ex     = occupied && ex_q;

    assign fwd_bus = {(occupied && gr_we_q) ? dest_q : 5'd0, result,
                      state == ST_WAIT && !rsp_live};
    assign {io.fwd_dest, io.fwd_data, io.fwd_busy} = fwd_bus;

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(io.req_fire && !io.data_ok && out_count == CNT_W'(MAX_OUT)));
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!resetn)
        !(io.data_ok && discard_cnt == '0 && state != ST_WAIT && !flush));

endmodule

// File: tb/tb_mem_load_stage.sv
// Directed bench for mem_load_stage (32- and 64-bit instances) with a
// queue scoreboard checked by a monitor on every WB handshake.
module tb_mem_load_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush32 = 1'b0;
    logic flush64 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp32[$];
    logic [63:0] exp64[$];

    always #5 clk = ~clk;

    mem_load_stage_if #(.DATA_W(32), .SB_W(16)) b32();
    mem_load_stage_if #(.DATA_W(64), .SB_W(16)) b64();

    mem_load_stage #(.DATA_W(32), .MAX_OUT(2), .SB_W(16)) u32 (
        .clk(clk), .resetn(resetn), .flush(flush32), .io(b32));
    mem_load_stage #(.DATA_W(64), .MAX_OUT(2), .SB_W(16)) u64 (
        .clk(clk), .resetn(resetn), .flush(flush64), .io(b64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && !flush32 && b32.out_valid && b32.out_ready) begin
            if (exp32.size() == 0) chk("unexpected_out32", {32'd0, b32.out_result}, 64'hX);
            else chk("out_result32", {32'd0, b32.out_result}, {32'd0, exp32.pop_front()});
        end
        if (resetn && !flush64 && b64.out_valid && b64.out_ready) begin
            if (exp64.size() == 0) chk("unexpected_out64", b64.out_result, 64'hX);
            else chk("out_result64", b64.out_result, exp64.pop_front());
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr32();
        b32.in_valid = 0; b32.in_is_load = 0; b32.in_ex = 0;
        b32.req_fire = 0; b32.data_ok = 0; flush32 = 0;
    endtask

    task automatic clr64();
        b64.in_valid = 0; b64.in_is_load = 0; b64.in_ex = 0;
        b64.req_fire = 0; b64.data_ok = 0; flush64 = 0;
    endtask

    task automatic issue32(input logic [31:0] res, input logic [1:0] sz, input logic sgn,
                           input logic ld, input logic ex, input logic [4:0] dst);
        b32.in_valid = 1; b32.in_result = res; b32.in_ld_size = sz;
        b32.in_ld_signed = sgn; b32.in_is_load = ld; b32.in_ex = ex;
        b32.in_dest = dst; b32.in_gr_we = 1; b32.in_pc = 32'h1c00_0000 + res;
        b32.req_fire = ld;
    endtask

    task automatic issue64(input logic [63:0] res, input logic [1:0] sz, input logic sgn);
        b64.in_valid = 1; b64.in_result = res; b64.in_ld_size = sz;
        b64.in_ld_signed = sgn; b64.in_is_load = 1; b64.in_ex = 0;
        b64.in_dest = 5'd9; b64.in_gr_we = 1; b64.in_pc = 32'h1c00_1000;
        b64.req_fire = 1;
    endtask

    initial begin
        b32.in_pc = '0; b32.in_result = '0; b32.in_dest = '0; b32.in_gr_we = 0;
        b32.in_ld_size = '0; b32.in_ld_signed = 0; b32.in_sb = 16'h00a5;
        b32.data_rdata = '0; b32.out_ready = 0;
        b64.in_pc = '0; b64.in_result = '0; b64.in_dest = '0; b64.in_gr_we = 0;
        b64.in_ld_size = '0; b64.in_ld_signed = 0; b64.in_sb = 16'h005a;
        b64.data_rdata = '0; b64.out_ready = 0;
        clr32();
        clr64();

        // Reset values
        #2;
        chk("rst_in_ready", {63'd0, b32.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, b32.out_valid}, 64'd0);
        chk("rst_mem_ex", {63'd0, b32.mem_ex}, 64'd0);
        chk("rst_fwd_dest", {59'd0, b32.fwd_dest}, 64'd0);
        chk("rst_fwd_busy", {63'd0, b32.fwd_busy}, 64'd0);
        chk("rst_out_result", {32'd0, b32.out_result}, 64'd0);
        nxt();
        resetn = 1;
        nxt();

        // ALU op
        issue32(32'h1234_5678, 2'd2, 0, 0, 0, 5'd5);
        b32.out_ready = 1;
        exp32.push_back(32'h1234_5678);
        @(negedge clk); chk("alu_in_ready", {63'd0, b32.in_ready}, 64'd1);
        nxt(); clr32();
        @(negedge clk);
        chk("alu_out_valid", {63'd0, b32.out_valid}, 64'd1);
        chk("alu_fwd_busy", {63'd0, b32.fwd_busy}, 64'd0);
        chk("alu_fwd_dest", {59'd0, b32.fwd_dest}, 64'd5);
        nxt();

        // ld.b signed, offset 3, response two cycles late
        issue32(32'h0000_1003, 2'd0, 1, 1, 0, 5'd6);
        nxt(); clr32();
        @(negedge clk);
        chk("ldb_busy1", {63'd0, b32.fwd_busy}, 64'd1);
        chk("ldb_wait_valid", {63'd0, b32.out_valid}, 64'd0);
        chk("ldb_fwd_dest", {59'd0, b32.fwd_dest}, 64'd6);
        nxt();
        @(negedge clk); chk("ldb_busy2", {63'd0, b32.fwd_busy}, 64'd1);
        nxt();
        b32.data_ok = 1; b32.data_rdata = 32'h80FF_0000;
        exp32.push_back(32'hFFFF_FF80);
        @(negedge clk);
        chk("ldb_busy_rsp", {63'd0, b32.fwd_busy}, 64'd0);
        chk("ldb_fwd_data", {32'd0, b32.fwd_data}, 64'hFFFF_FF80);
        nxt(); clr32();

        // ld.hu, offset 2, response while WB stalls
        issue32(32'h0000_2002, 2'd1, 0, 1, 0, 5'd7);
        b32.out_ready = 0;
        nxt(); clr32();
        b32.data_ok = 1; b32.data_rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("ldhu_bypass_valid", {63'd0, b32.out_valid}, 64'd1);
        chk("ldhu_bypass_data", {32'd0, b32.out_result}, 64'h80FF);
        nxt(); clr32();
        b32.data_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("ldhu_hold_valid", {63'd0, b32.out_valid}, 64'd1);
        chk("ldhu_hold_data", {32'd0, b32.out_result}, 64'h80FF);
        chk("ldhu_hold_busy", {63'd0, b32.fwd_busy}, 64'd0);
        nxt();
        b32.out_ready = 1;
        exp32.push_back(32'h0000_80FF);
        nxt();

        // Two in flight, flush, drain two stale responses, deliver the third
        issue32(32'h0000_3000, 2'd2, 0, 1, 0, 5'd8);
        nxt(); clr32();
        b32.req_fire = 1;
        @(negedge clk); chk("drain_busy", {63'd0, b32.fwd_busy}, 64'd1);
        nxt(); clr32();
        flush32 = 1;
        @(negedge clk); chk("drain_flush_in_ready", {63'd0, b32.in_ready}, 64'd0);
        nxt(); clr32();
        b32.data_ok = 1; b32.data_rdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("drain_rsp1_valid", {63'd0, b32.out_valid}, 64'd0);
        nxt(); clr32();
        issue32(32'h0000_4000, 2'd2, 0, 1, 0, 5'd10);
        b32.data_ok = 1; b32.data_rdata = 32'hCAFE_F00D;
        @(negedge clk); chk("drain_rsp2_valid", {63'd0, b32.out_valid}, 64'd0);
        nxt(); clr32();
        b32.data_ok = 1; b32.data_rdata = 32'h1122_3344;
        exp32.push_back(32'h1122_3344);
        @(negedge clk); chk("drain_rsp3_valid", {63'd0, b32.out_valid}, 64'd1);
        nxt(); clr32();
        @(negedge clk);
        chk("drain_discard_zero", {62'd0, u32.discard_cnt}, 64'd0);
        chk("drain_count_zero", {62'd0, u32.out_count}, 64'd0);
        nxt();

        // Exception instruction held by WB, then flushed
        b32.out_ready = 0;
        issue32(32'h0000_5000, 2'd2, 0, 0, 1, 5'd11);
        nxt(); clr32();
        @(negedge clk); chk("ex_mem_ex1", {63'd0, b32.mem_ex}, 64'd1);
        nxt();
        @(negedge clk); chk("ex_mem_ex2", {63'd0, b32.mem_ex}, 64'd1);
        nxt();
        flush32 = 1; b32.out_ready = 1;
        issue32(32'h0000_6000, 2'd2, 0, 0, 0, 5'd12);
        @(negedge clk); chk("ex_flush_in_ready", {63'd0, b32.in_ready}, 64'd0);
        nxt(); clr32();
        b32.out_ready = 0;
        @(negedge clk);
        chk("ex_cleared_mem_ex", {63'd0, b32.mem_ex}, 64'd0);
        chk("ex_cleared_valid", {63'd0, b32.out_valid}, 64'd0);
        nxt();

        // 64-bit datapath
        b64.out_ready = 1;
        issue64(64'h8000, 2'd3, 0);
        nxt(); clr64();
        b64.data_ok = 1; b64.data_rdata = 64'h0123_4567_89AB_CDEF;
        exp64.push_back(64'h0123_4567_89AB_CDEF);
        nxt(); clr64();
        issue64(64'h8004, 2'd2, 1);
        nxt(); clr64();
        b64.data_ok = 1; b64.data_rdata = 64'h0123_4567_89AB_CDEF;
        exp64.push_back(64'h0000_0000_0123_4567);
        nxt(); clr64();
        issue64(64'h8002, 2'd1, 1);
        nxt(); clr64();
        b64.data_ok = 1; b64.data_rdata = 64'h0123_4567_89AB_CDEF;
        exp64.push_back(64'hFFFF_FFFF_FFFF_89AB);
        nxt(); clr64();

        // Asynchronous reset in the middle of a WAIT
        b64.out_ready = 0;
        issue64(64'h8000, 2'd3, 0);
        nxt(); clr64();
        b64.data_ok = 1; b64.data_rdata = 64'h5555_AAAA_5555_AAAA;
        #2;
        chk("arst_pre_valid", {63'd0, b64.out_valid}, 64'd1);
        resetn = 0;
        #1;
        chk("arst_out_valid", {63'd0, b64.out_valid}, 64'd0);
        chk("arst_fwd_busy", {63'd0, b64.fwd_busy}, 64'd0);
        chk("arst_in_ready", {63'd0, b64.in_ready}, 64'd1);
        clr64();
        nxt();
        resetn = 1;
        nxt();

        chk("sb32_drained", 64'(exp32.size()), 64'd0);
        chk("sb64_drained", 64'(exp64.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
